// File: rtl/float_pkg.sv
// Shared float constants, FSM state type and int32 saturation values.
package float_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'd255;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        CLASS,
        SHIFT,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/float_unpack.sv
// Splits an IEEE-754 single into fields and flags its special classes.
module float_unpack
    import float_pkg::*;
(
    input  logic [31:0]       v,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W:0]   sig,
    output logic              is_zero,
    output logic              is_denorm,
    output logic              is_inf,
    output logic              is_nan
);

    logic [MANT_W-1:0] frac;
    logic              exp_zero;
    logic              exp_ones;

    // Field extraction; the hidden bit is only present for normal numbers.
    always_comb begin
        sign      = v[31];
        exp       = v[MANT_W +: EXP_W];
        frac      = v[MANT_W-1:0];
        exp_zero  = (exp == '0);
        exp_ones  = (exp == EXP_SPECIAL);
        sig       = {!exp_zero, frac};
        is_zero   = exp_zero && (frac == '0);
        is_denorm = exp_zero && (frac != '0);
        is_inf    = exp_ones && (frac == '0);
        is_nan    = exp_ones && (frac != '0);
    end

endmodule

// File: rtl/float_to_int.sv
// Float to int32 conversion, round toward zero, one bit of shift per cycle.
module float_to_int
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ires,
    output logic        ovf,
    output logic        nan
);

    localparam logic signed [9:0] BIAS10 = 10'(EXP_BIAS);

    state_t state_q, state_d;

    logic              u_sign;
    logic [EXP_W-1:0]  u_exp;
    logic [MANT_W:0]   u_sig;
    logic              u_zero, u_denorm, u_inf, u_nan;

    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W:0]   sig_q;
    logic              small_q, inf_q, nan_in_q;

    logic [31:0]       mag_q;
    logic [4:0]        cnt_q;
    logic              left_q;
    logic              nan_case_q, ovf_case_q, exact_min_q;

    logic signed [9:0] e_c, d_c;
    logic [4:0]        k_c;
    logic              cls_nan, cls_ovf, cls_zero, cls_exact;

    float_unpack u_unpack (
        .v         (v),
        .sign      (u_sign),
        .exp       (u_exp),
        .sig       (u_sig),
        .is_zero   (u_zero),
        .is_denorm (u_denorm),
        .is_inf    (u_inf),
        .is_nan    (u_nan)
    );

    // Classify the captured operand: unbiased exponent, shift distance and routing.
    always_comb begin
        e_c       = $signed({2'b00, exp_q}) - BIAS10;
        d_c       = e_c - 10'sd23;
        k_c       = d_c[9] ? 5'(-d_c) : 5'(d_c);
        cls_nan   = nan_in_q;
        cls_ovf   = !nan_in_q && (inf_q || (e_c >= 10'sd31));
        cls_zero  = !nan_in_q && !cls_ovf && (small_q || (e_c < 10'sd0));
        cls_exact = sign_q && (e_c == 10'sd31) && (sig_q[MANT_W-1:0] == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CLASS;
            CLASS:   if (cls_nan || cls_ovf || cls_zero || (k_c == 5'd0)) state_d = FIX;
                     else state_d = SHIFT;
            SHIFT:   if (cnt_q <= 5'd1) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath: capture, load the magnitude, shift serially, then saturate or negate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            small_q     <= 1'b0;
            inf_q       <= 1'b0;
            nan_in_q    <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            nan_case_q  <= 1'b0;
            ovf_case_q  <= 1'b0;
            exact_min_q <= 1'b0;
            ires        <= '0;
            ovf         <= 1'b0;
            nan         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= u_sign;
                        exp_q    <= u_exp;
                        sig_q    <= u_sig;
                        small_q  <= u_zero || u_denorm;
                        inf_q    <= u_inf;
                        nan_in_q <= u_nan;
                    end
                end
                CLASS: begin
                    nan_case_q  <= cls_nan;
                    ovf_case_q  <= cls_ovf;
                    exact_min_q <= cls_exact;
                    left_q      <= (d_c > 10'sd0);
                    cnt_q       <= (cls_nan || cls_ovf || cls_zero) ? 5'd0 : k_c;
                    mag_q       <= cls_zero ? 32'd0 : {{(32-MANT_W-1){1'b0}}, sig_q};
                end
                SHIFT: begin
                    mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
                    cnt_q <= cnt_q - 5'd1;
                end
                FIX: begin
                    if (nan_case_q) begin
                        ires <= '0;
                        ovf  <= 1'b0;
                        nan  <= 1'b1;
                    end else if (ovf_case_q) begin
                        ires <= sign_q ? INT_MIN : INT_MAX;
                        ovf  <= !(sign_q && exact_min_q);
                        nan  <= 1'b0;
                    end else begin
                        ires <= sign_q ? (~mag_q + 32'd1) : mag_q;
                        ovf  <= 1'b0;
                        nan  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Directed vector bench for float_to_int: table of conversions plus corner sequences.
module tb_float_to_int;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] v;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ires;
    logic        ovf;
    logic        nan;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] v;
        logic [31:0] ires;
        logic        ovf;
        logic        nan;
        int          lat;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    localparam int NB2B = 5;
    logic [31:0] b2b_ops [NB2B];
    logic [31:0] b2b_exp [NB2B];

    logic [31:0] r_ires;
    logic        r_ovf;
    logic        r_nan;
    int          lat;

    float_to_int dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .v         (v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ires      (ires),
        .ovf       (ovf),
        .nan       (nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp_val);
        end
    endtask

    // Offers one operand, checks it is accepted, then counts edges until out_valid.
    task automatic applyStimulus(input logic [31:0] val, output logic [31:0] o_ires,
                                 output logic o_ovf, output logic o_nan, output int o_lat);
        int w;
        w = 0;
        while (!in_ready && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        v        = val;
        @(posedge clk); #1;
        in_valid = 1'b0;
        v        = 32'hDEAD_BEEF;
        checkOutput("accepted", {31'd0, in_ready}, 32'd0);
        o_lat = 1;
        while (!out_valid && o_lat < 40) begin
            @(posedge clk); #1;
            o_lat++;
        end
        o_ires = ires;
        o_ovf  = ovf;
        o_nan  = nan;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        v         = '0;
        out_ready = 1'b1;

        vecs[0]  = '{32'h42F6_CCCD, 32'h0000_007B, 1'b0, 1'b0, 20};
        vecs[1]  = '{32'hC0E8_0000, 32'hFFFF_FFF9, 1'b0, 1'b0, 24};
        vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 3};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 3};
        vecs[4]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3};
        vecs[5]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 3};
        vecs[6]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 3};
        vecs[7]  = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3};
        vecs[8]  = '{32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 3};
        vecs[9]  = '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b0, 26};
        vecs[10] = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 3};
        vecs[11] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 10};
        vecs[12] = '{32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 10};
        vecs[13] = '{32'h3F7F_FFFF, 32'h0000_0000, 1'b0, 1'b0, 3};
        vecs[14] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 3};
        vecs[15] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 3};
        vecs[16] = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 26};
        vecs[17] = '{32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 26};
        vecs[18] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 1'b0, 3};
        vecs[19] = '{32'h4B80_0000, 32'h0100_0000, 1'b0, 1'b0, 4};
        vecs[20] = '{32'hFFC0_0001, 32'h0000_0000, 1'b0, 1'b1, 3};

        b2b_ops[0] = 32'h4040_0000; b2b_exp[0] = 32'h0000_0003;
        b2b_ops[1] = 32'hC120_0000; b2b_exp[1] = 32'hFFFF_FFF6;
        b2b_ops[2] = 32'h4B00_0000; b2b_exp[2] = 32'h0080_0000;
        b2b_ops[3] = 32'h0000_0000; b2b_exp[3] = 32'h0000_0000;
        b2b_ops[4] = 32'h447A_0000; b2b_exp[4] = 32'h0000_03E8;

        // Reset state
        #12;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_ires", ires, 32'd0);
        checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
        checkOutput("reset_nan", {31'd0, nan}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of directed conversions with out_ready held high
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].v, r_ires, r_ovf, r_nan, lat);
            checkOutput($sformatf("vec%0d_ires", i), r_ires, vecs[i].ires);
            checkOutput($sformatf("vec%0d_ovf", i), {31'd0, r_ovf}, {31'd0, vecs[i].ovf});
            checkOutput($sformatf("vec%0d_nan", i), {31'd0, r_nan}, {31'd0, vecs[i].nan});
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_release", i), {30'd0, out_valid, in_ready}, 32'd1);
        end

        // NaN result held while the consumer stalls; a new operand must be ignored
        out_ready = 1'b0;
        applyStimulus(32'h7FC0_0000, r_ires, r_ovf, r_nan, lat);
        checkOutput("hold_latency", 32'(lat), 32'd3);
        in_valid = 1'b1;
        v        = 32'h3F80_0000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("hold%0d_ires", c), ires, 32'd0);
            checkOutput($sformatf("hold%0d_nan", c), {31'd0, nan}, 32'd1);
            checkOutput($sformatf("hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("hold_release", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset pulse in the middle of a shift abandons 123.4
        in_valid = 1'b1;
        v        = 32'h42F6_CCCD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_ires", ires, 32'd0);
        #2;
        rst = 1'b0;
        applyStimulus(32'h3FC0_0000, r_ires, r_ovf, r_nan, lat);
        checkOutput("after_rst_ires", r_ires, 32'd1);
        checkOutput("after_rst_latency", 32'(lat), 32'd26);
        @(posedge clk); #1;

        // Back-to-back operands with in_valid held high
        begin
            int idx;
            int got;
            int extra;
            logic acc;
            logic tk;
            logic [31:0] cap;
            idx      = 0;
            got      = 0;
            extra    = 0;
            in_valid = 1'b1;
            v        = b2b_ops[0];
            for (int c = 0; c < 400 && got < NB2B; c++) begin
                acc = in_valid && in_ready;
                tk  = out_valid && out_ready;
                cap = ires;
                @(posedge clk); #1;
                if (tk) begin
                    checkOutput($sformatf("b2b%0d_ires", got), cap, b2b_exp[got]);
                    got++;
                end
                if (acc) begin
                    idx++;
                    if (idx < NB2B) v = b2b_ops[idx];
                    else            in_valid = 1'b0;
                end
            end
            checkOutput("b2b_count", 32'(got), 32'(NB2B));
            checkOutput("b2b_accepts", 32'(idx), 32'(NB2B));
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (out_valid) extra++;
            end
            checkOutput("b2b_no_extra", 32'(extra), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have the port in_valid, input, 1 bit: the operand on v is valid.
REQ-004 SHALL have the port in_ready, output, 1 bit: the block accepts an operand; high only in IDLE.
REQ-005 SHALL have the port v, input, 32 bits: IEEE-754 single operand, the same format as float_addsub vres.
REQ-006 SHALL have the port out_valid, output, 1 bit: ires, ovf and nan are valid.
REQ-007 SHALL have the port out_ready, input, 1 bit: the consumer takes the result.
REQ-008 SHALL have the port ires, output, 32 bits: signed two's-complement result.
REQ-009 SHALL have the port ovf, output, 1 bit: the result saturated (out of range or infinity).
REQ-010 SHALL have the port nan, output, 1 bit: the operand was a NaN.

Function
REQ-011 SHALL convert the float to int32 with round-toward-zero (C cast semantics), one operand at a time.
REQ-012 SHALL use the states IDLE, CLASS, SHIFT, FIX, DONE.
REQ-013 IDLE SHALL assert in_ready; on in_valid&&in_ready it SHALL capture the sign, exponent and mantissa (hidden bit prepended when exp!=0) and go to CLASS.
REQ-014 CLASS SHALL compute e = exp-127 and route the operand as follows:
- exp==255 with mant!=0: NaN case, go to FIX.
- exp==255 with mant==0, or e>=31: overflow case, go to FIX.
- e<0, which includes zero and denormals: magnitude 0, go to FIX.
- otherwise k = |e-23|; go to SHIFT if k>0, else go to FIX.
REQ-015 SHIFT SHALL shift the 32-bit magnitude one bit per cycle, right if e<23 and left if e>23, decrement k, and go to FIX when k reaches 0.
REQ-016 Bits shifted out to the right SHALL be discarded (truncation).
REQ-017 FIX SHALL produce these results:
- NaN: ires=0, nan=1.
- Overflow, positive: ires=32'h7FFF_FFFF, ovf=1.
- Overflow, negative: ires=32'h8000_0000, ovf=1, except the exact -2^31 input (32'hCF00_0000), which gives ovf=0.
- Otherwise: ires = sign ? -mag : mag.
- All cases: go to DONE.
REQ-018 DONE SHALL hold out_valid=1 with ires, ovf and nan stable until out_ready; on out_valid&&out_ready it SHALL return to IDLE.
REQ-019 Latency SHALL be exactly 3+k rising edges from the accept edge to out_valid high; k=0 for the NaN, overflow and e<0 cases; the maximum is 26.
REQ-020 in_ready SHALL be low in every state other than IDLE, so a new accept can occur no earlier than the cycle after the out_ready handshake.
REQ-021 The sign of negative zero SHALL be ignored: ires=0.
REQ-022 Changes on v or in_valid while busy SHALL have no effect.

Reset
REQ-023 rst SHALL force the state to IDLE immediately, independent of clk.
REQ-024 Reset values SHALL be in_ready=1 (follows IDLE), out_valid=0, ires=0, ovf=0, nan=0, shift counter=0.
REQ-025 Reset mid-conversion (in CLASS, SHIFT, FIX or DONE) SHALL abandon the operand without producing a result.
REQ-026 The first accept after reset release SHALL be possible on the first rising edge with rst low.

Structure
REQ-027 A shared package float_pkg SHALL hold:
- the constants EXP_BIAS=127, EXP_W=8, MANT_W=23, EXP_SPECIAL=255;
- the state enum type;
- the saturation constants INT_MAX and INT_MIN.
REQ-028 A combinational sub-module float_unpack SHALL split v into sign, exp and the 24-bit significand with the hidden bit, and flag zero, denormal, infinity and NaN; it is reusable by float_addsub.
REQ-029 The datapath SHALL be a single 32-bit shift register plus a 5-bit counter; no barrel shifter.

Verification
REQ-030 v=32'h42F6_CCCD (123.4), out_ready=1 -> ires=32'h0000_007B, ovf=0, nan=0; out_valid 20 edges after accept.
REQ-031 v=32'hC0E8_0000 (-7.25) -> ires=32'hFFFF_FFF9 (-7); v=32'h0000_0000 and v=32'h8000_0000 -> ires=0, latency 3.
REQ-032 v=32'h4F00_0000 (2^31) -> ires=32'h7FFF_FFFF, ovf=1; v=32'hCF00_0000 -> ires=32'h8000_0000, ovf=0; v=32'hFF80_0000 (-inf) -> ires=32'h8000_0000, ovf=1.
REQ-033 v=32'h7FC0_0000 (NaN) -> ires=0, nan=1; hold out_ready=0 for 5 cycles -> out_valid and ires stay stable and in_ready stays 0 throughout.
REQ-034 Pulse rst during SHIFT of 123.4 -> out_valid stays 0 and in_ready=1 immediately; the next operand 32'h3FC0_0000 (1.5) -> ires=1.
REQ-035 Back-to-back operands with in_valid held high -> one conversion per handshake, results in order, none lost or duplicated.
